// File: rtl/match_timer.sv
// Match timer: BCD minutes/seconds display counting down to 00:00 or up to the preset,
// with start/pause/load control, a low-time warning and a one-cycle completion pulse.
module match_timer #(
    parameter int START_MIN  = 2,
    parameter int START_SEC  = 0,
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 50000000,
    parameter int WARN_SEC   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    load,
    input  logic                    mode,
    output logic [4*MIN_DIGITS-1:0] min,
    output logic [3:0]              sec1,
    output logic [3:0]              sec2,
    output logic                    running,
    output logic                    expired,
    output logic                    done_pulse,
    output logic                    warn
);
    localparam int MW = 4 * MIN_DIGITS;
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    function automatic logic [MW-1:0] to_bcd(input int value);
        int             rest;
        logic [MW-1:0]  res;
        rest = value;
        res  = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            res[4*i +: 4] = 4'(rest % 10);
            rest          = rest / 10;
        end
        return res;
    endfunction

    function automatic int total_sec(input logic [MW-1:0] m, input logic [3:0] s1,
                                     input logic [3:0] s2);
        int mins;
        int weight;
        mins   = 0;
        weight = 1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            mins   = mins + weight * int'(m[4*i +: 4]);
            weight = weight * 10;
        end
        return mins * 60 + int'(s1) * 10 + int'(s2);
    endfunction

    // BCD increment/decrement of the minute field, rippling carry or borrow digit by digit.
    function automatic logic [MW-1:0] min_step(input logic [MW-1:0] m, input logic up);
        logic [MW-1:0] res;
        logic          carry;
        res   = m;
        carry = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    if (m[4*i +: 4] == 4'd9) res[4*i +: 4] = 4'd0;
                    else begin
                        res[4*i +: 4] = m[4*i +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end else begin
                    if (m[4*i +: 4] == 4'd0) res[4*i +: 4] = 4'd9;
                    else begin
                        res[4*i +: 4] = m[4*i +: 4] - 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    localparam logic [MW-1:0] PRESET_MIN = to_bcd(START_MIN);
    localparam logic [3:0]    PRESET_S1  = 4'(START_SEC / 10);
    localparam logic [3:0]    PRESET_S2  = 4'(START_SEC % 10);

    function automatic logic is_term(input logic [MW-1:0] m, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic up);
        if (up) return {m, s1, s2} == {PRESET_MIN, PRESET_S1, PRESET_S2};
        return {m, s1, s2} == '0;
    endfunction

    state_t         state, state_n;
    logic           mode_q, mode_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [MW-1:0]  min_n, s_min;
    logic [3:0]     sec1_n, sec2_n, s_sec1, s_sec2;
    logic           warn_n;
    int             rem;

    // One display step in the latched direction, independent of whether it is taken.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        s_min  = min;
        s_sec1 = sec1;
        s_sec2 = sec2;
        if (!mode_q) begin
            if (sec2 != 4'd0) s_sec2 = sec2 - 4'd1;
            else if (sec1 != 4'd0) begin
                s_sec1 = sec1 - 4'd1;
                s_sec2 = 4'd9;
            end else begin
                s_sec1 = 4'd5;
                s_sec2 = 4'd9;
                s_min  = min_step(min, 1'b0);
            end
        end else begin
            if (sec2 != 4'd9) s_sec2 = sec2 + 4'd1;
            else if (sec1 != 4'd5) begin
                s_sec1 = sec1 + 4'd1;
                s_sec2 = 4'd0;
            end else begin
                s_sec1 = 4'd0;
                s_sec2 = 4'd0;
                s_min  = min_step(min, 1'b1);
            end
        end
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        cnt_n   = cnt;
        min_n   = min;
        sec1_n  = sec1;
        sec2_n  = sec2;
        if (load) begin
            state_n = IDLE;
            mode_n  = mode;
            cnt_n   = '0;
            min_n   = mode ? '0 : PRESET_MIN;
            sec1_n  = mode ? 4'd0 : PRESET_S1;
            sec2_n  = mode ? 4'd0 : PRESET_S2;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (start) state_n = is_term(min, sec1, sec2, mode_q) ? DONE : RUN;
                end
                RUN: begin
                    // A pause request discards any tick due this cycle and freezes the prescaler.
                    if (pause) state_n = PAUSE;
                    else if (cnt == CW'(TICK_DIV - 1)) begin
                        cnt_n  = '0;
                        min_n  = s_min;
                        sec1_n = s_sec1;
                        sec2_n = s_sec2;
                        if (is_term(s_min, s_sec1, s_sec2, mode_q)) state_n = DONE;
                    end else cnt_n = cnt + 1'b1;
                end
                PAUSE: if (start && !pause) state_n = RUN;
                DONE:  cnt_n = '0;
            endcase
        end

        rem    = total_sec(min_n, sec1_n, sec2_n);
        warn_n = (state_n == RUN || state_n == PAUSE) && !mode_n && rem >= 1 && rem <= WARN_SEC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            cnt        <= '0;
            min        <= PRESET_MIN;
            sec1       <= PRESET_S1;
            sec2       <= PRESET_S2;
            running    <= 1'b0;
            expired    <= 1'b0;
            done_pulse <= 1'b0;
            warn       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            state      <= state_n;
            mode_q     <= mode_n;
            cnt        <= cnt_n;
            min        <= min_n;
            sec1       <= sec1_n;
            sec2       <= sec2_n;
            running    <= (state_n == RUN);
            expired    <= (state_n == DONE);
            done_pulse <= (state_n == DONE) && (state != DONE);
            warn       <= warn_n;
        end
    end
endmodule

// File: doc/match_timer.md
MATCH_TIMER -- requirements
Module: match_timer

Interface
REQ-001 The block SHALL have parameter START_MIN, default 2, preset minutes in BCD range 0..10^MIN_DIGITS-1.
REQ-002 The block SHALL have parameter START_SEC, default 0, preset seconds in range 0..59.
REQ-003 The block SHALL have parameter MIN_DIGITS, default 1, number of BCD minute digits in range 1..2.
REQ-004 The block SHALL have parameter TICK_DIV, default 50000000, clk cycles per counted second (>=2).
REQ-005 The block SHALL have parameter WARN_SEC, default 10, warning threshold in total seconds.
REQ-006 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  go request; honoured in IDLE and PAUSE.
REQ-009 pause  input  1  pause request; honoured in RUN.
REQ-010 load  input  1  synchronous reload of preset and mode; highest priority.
REQ-011 mode  input  1  count direction sampled on load: 0 = down from preset to 00:00, 1 = up from 00:00 to preset.
REQ-012 min  output  4*MIN_DIGITS  minutes as packed BCD, most significant digit in the top nibble.
REQ-013 sec1  output  4  seconds tens digit, BCD 0..5.
REQ-014 sec2  output  4  seconds ones digit, BCD 0..9.
REQ-015 running  output  1  high while in RUN.
REQ-016 expired  output  1  high while in DONE.
REQ-017 done_pulse  output  1  single-cycle pulse on entry to DONE.
REQ-018 warn  output  1  low-time warning flag.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-020 Transition IDLE->RUN SHALL occur on start=1.
REQ-021 Transition RUN->PAUSE SHALL occur on pause=1.
REQ-022 Transition PAUSE->RUN SHALL occur on start=1 with pause=0.
REQ-023 Transition RUN->DONE SHALL occur on the tick that reaches the terminal value.
REQ-024 Transition any state->IDLE SHALL occur on load=1.
REQ-025 Priority SHALL be load > pause > start; start and pause both high in RUN or PAUSE SHALL result in PAUSE.
REQ-026 On load, the block SHALL latch mode, set digits to the preset (mode 0) or 00:00 (mode 1), clear the prescaler, done_pulse and warn.
REQ-027 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold in PAUSE, clear in IDLE and DONE, and emit an internal tick when it wraps from TICK_DIV-1 to 0.
REQ-028 A tick in the same cycle as pause=1 SHALL be discarded, with the digits and the prescaler unchanged.
REQ-029 Down step: sec2 SHALL decrement; at 0, sec2 SHALL become 9 and sec1 SHALL decrement; when sec1:sec2 is 00, they SHALL become 59 and min SHALL decrement in BCD with borrow across digits.
REQ-030 Up step: sec2 SHALL increment; at 9, sec2 SHALL become 0 and sec1 SHALL increment; when sec1:sec2 is 59, they SHALL become 00 and min SHALL increment in BCD with carry across digits.
REQ-031 The terminal value SHALL be 00:00 in mode 0 and START_MIN:START_SEC in mode 1; digits SHALL never pass the terminal and SHALL hold in DONE.
REQ-032 If start is taken in IDLE while the digits already equal the terminal, the block SHALL enter DONE on the next cycle with done_pulse high for one cycle.
REQ-033 warn SHALL be 1 only in RUN or PAUSE with mode 0 and remaining total seconds in range 1..WARN_SEC, and 0 otherwise.
REQ-034 All outputs SHALL be registered, and the digits SHALL always hold valid BCD.

Reset
REQ-035 On rst=0 the block SHALL force state IDLE, mode 0, min=START_MIN, sec1:sec2=START_SEC, prescaler 0, and running, expired, done_pulse, warn all 0.
REQ-036 Reset asserted mid-RUN SHALL abort immediately with no done_pulse.
REQ-037 After release of rst, the block SHALL hold IDLE until start or load.

Verification (TICK_DIV=4, defaults otherwise)
REQ-038 Scenario: reset, then start=1 for one cycle -> running=1; after 4 clk the display reads 1:59; after 480 clk from start it reads 0:00, expired=1, and done_pulse is high for exactly one cycle.
REQ-039 Scenario: run to 0:11, then step -> warn=1 at 0:10 and stays high through 0:01; warn=0 in DONE.
REQ-040 Scenario: pause asserted for 20 clk at prescaler count 2, then start -> the digits are frozen during the pause and the next step occurs 2 clk after resume.
REQ-041 Scenario: load with mode=1, then start -> the display counts 0:00, 0:01 ... 0:59, 1:00 ... 2:00, then DONE; warn stays 0 throughout.
REQ-042 Scenario: MIN_DIGITS=2, START_MIN=10, down mode -> the tick from 10:00 yields 09:59, with min=8'h09.
REQ-043 Scenario: rst pulsed low mid-RUN at 1:23 -> the display reads 2:00 and state is IDLE asynchronously, with no done_pulse; load and start asserted together -> IDLE with preset, start ignored.
